// File: rtl/instr_queue.sv
// instr_queue: FIFO of fetched instructions tagged with their fetch address.
// It sits between instruction memory and decode. The oldest entry is shown on
// Q/PC_Q (first-word fall-through). When the queue is empty, Q/PC_Q read as
// zero, so decode sees a NOP. FLUSH discards every buffered entry at once.
module instr_queue #(
  parameter int DWL   = 32,
  parameter int AWL   = 6,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic           CLK,
  input  logic           RSTN,
  input  logic           FLUSH,
  input  logic           WR_EN,
  input  logic [DWL-1:0] D,
  input  logic [AWL-1:0] PC_D,
  output logic           FULL,
  input  logic           RD_EN,
  output logic           VALID,
  output logic [DWL-1:0] Q,
  output logic [AWL-1:0] PC_Q,
  output logic [CW-1:0]  COUNT,
  output logic           OVF
);

  logic [AWL+DWL-1:0] mem [DEPTH];
  logic [PW-1:0]      wp;
  logic [PW-1:0]      rp;
  logic [CW-1:0]      count;
  logic               ovf;
  logic               push;
  logic               pop;
  logic               reject;
  logic [AWL+DWL-1:0] head;

  // FULL and VALID decode registered occupancy only, never the request inputs.
  assign FULL  = (count == CW'(DEPTH));
  assign VALID = (count != '0);
  assign COUNT = count;
  assign OVF   = ovf;

  // A pop in the same cycle frees a slot, so a push into a full queue is still
  // accepted. A pop from an empty queue is simply ignored.
  assign push   = WR_EN && (!FULL || RD_EN);
  assign pop    = RD_EN && VALID;
  assign reject = WR_EN && FULL && !RD_EN;

  // Storage write. It has no reset, and a flush leaves the contents in place;
  // only the pointers and the count are cleared.
  always_ff @(posedge CLK) begin
    if (push && !FLUSH) begin
      mem[wp] <= {PC_D, D};
    end
  end

  // Pointers, occupancy and sticky overflow. FLUSH overrides any push or pop.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (FLUSH) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wp <= wp + PW'(1);
      end
      if (pop) begin
        rp <= rp + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      if (reject) begin
        ovf <= 1'b1;
      end
    end
  end

  // Head read, forced to zero when empty so that decode receives a NOP.
  assign head = VALID ? mem[rp] : '0;
  assign Q    = head[DWL-1:0];
  assign PC_Q = head[AWL+DWL-1:DWL];

endmodule

// File: tb/tb_instr_queue.sv
// Testbench for instr_queue. The driver applies a stimulus on each falling edge
// and steps a queue-based reference model. It then pushes the expected
// post-edge state into a scoreboard. A monitor pops one expectation after
// every rising edge and compares it with the DUT outputs.
module tb_instr_queue;
  localparam int DWL   = 32;
  localparam int AWL   = 6;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic           CLK = 1'b0;
  logic           RSTN;
  logic           FLUSH;
  logic           WR_EN;
  logic [DWL-1:0] D;
  logic [AWL-1:0] PC_D;
  logic           FULL;
  logic           RD_EN;
  logic           VALID;
  logic [DWL-1:0] Q;
  logic [AWL-1:0] PC_Q;
  logic [CW-1:0]  COUNT;
  logic           OVF;

  instr_queue #(.DWL(DWL), .AWL(AWL), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RSTN(RSTN), .FLUSH(FLUSH), .WR_EN(WR_EN), .D(D), .PC_D(PC_D),
    .FULL(FULL), .RD_EN(RD_EN), .VALID(VALID), .Q(Q), .PC_Q(PC_Q),
    .COUNT(COUNT), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int             cnt;
    bit             ovf;
    logic [DWL-1:0] q;
    logic [AWL-1:0] pc;
  } exp_t;

  exp_t                 sb[$];
  logic [AWL+DWL-1:0]   mq[$];
  bit                   m_ovf;
  int                   n_chk  = 0;
  int                   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: a plain queue that follows the push/pop/flush rules.
  task automatic model_step(input bit wr, input bit rd, input bit fl,
                            input logic [DWL-1:0] d, input logic [AWL-1:0] pc);
    exp_t e;
    bit   acc_push;
    bit   acc_pop;
    if (fl) begin
      mq.delete();
    end else begin
      acc_push = wr && ((mq.size() < DEPTH) || rd);
      acc_pop  = rd && (mq.size() > 0);
      if (wr && !acc_push) m_ovf = 1'b1;
      if (acc_pop) void'(mq.pop_front());
      if (acc_push) mq.push_back({pc, d});
    end
    e.cnt = mq.size();
    e.ovf = m_ovf;
    e.q   = (mq.size() > 0) ? mq[0][DWL-1:0] : '0;
    e.pc  = (mq.size() > 0) ? mq[0][AWL+DWL-1:DWL] : '0;
    sb.push_back(e);
  endtask

  task automatic cyc(input bit wr, input bit rd, input bit fl,
                     input logic [DWL-1:0] d, input logic [AWL-1:0] pc);
    @(negedge CLK);
    WR_EN = wr; RD_EN = rd; FLUSH = fl; D = d; PC_D = pc;
    model_step(wr, rd, fl, d, pc);
  endtask

  // Monitor: after each rising edge, compare the DUT with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("count", 64'(COUNT), 64'(e.cnt));
        chk("valid", 64'(VALID), 64'(e.cnt != 0));
        chk("full",  64'(FULL),  64'(e.cnt == DEPTH));
        chk("q",     64'(Q),     64'(e.q));
        chk("pc_q",  64'(PC_Q),  64'(e.pc));
        chk("ovf",   64'(OVF),   64'(e.ovf));
      end
    end
  end

  initial begin
    logic [DWL-1:0] v;
    RSTN = 1'b0; FLUSH = 1'b0; WR_EN = 1'b0; RD_EN = 1'b0; D = '0; PC_D = '0;
    m_ovf = 1'b0;
    #2;
    chk("rst_count", 64'(COUNT), 64'd0);
    chk("rst_valid", 64'(VALID), 64'd0);
    chk("rst_full",  64'(FULL),  64'd0);
    chk("rst_q",     64'(Q),     64'd0);
    chk("rst_pc_q",  64'(PC_Q),  64'd0);
    chk("rst_ovf",   64'(OVF),   64'd0);
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;

    // Fill with four words, then overflow, then a push and pop while full.
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 32'h11111111 * (i + 1), AWL'(i));
    cyc(1, 0, 0, 32'h55555555, 6'd4);
    cyc(1, 1, 0, 32'hAAAAAAAA, 6'd5);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, '0, '0);

    // Wrap-around: two entries, then ten cycles of push and pop together.
    v = 32'h1000;
    for (int i = 0; i < 2; i++) begin cyc(1, 0, 0, v, AWL'(v)); v++; end
    for (int i = 0; i < 10; i++) begin cyc(1, 1, 0, v, AWL'(v)); v++; end
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, '0, '0);

    // Empty queue: a pop is ignored; a push with RD_EN set is accepted.
    cyc(0, 1, 0, '0, '0);
    cyc(1, 1, 0, 32'hCAFEF00D, 6'd33);
    cyc(0, 0, 0, '0, '0);

    // Flush at COUNT = 3 together with a push.
    cyc(1, 0, 0, 32'h2, 6'd2);
    cyc(1, 0, 0, 32'h3, 6'd3);
    cyc(1, 1, 1, 32'hDEAD, 6'd9);
    cyc(0, 0, 0, '0, '0);

    // Asynchronous reset between clock edges.
    cyc(1, 0, 0, 32'h77, 6'd7);
    @(posedge CLK);
    #3;
    RSTN = 1'b0; WR_EN = 1'b0; RD_EN = 1'b0; FLUSH = 1'b0;
    #1;
    chk("async_count", 64'(COUNT), 64'd0);
    chk("async_valid", 64'(VALID), 64'd0);
    chk("async_q",     64'(Q),     64'd0);
    chk("async_ovf",   64'(OVF),   64'd0);
    mq.delete();
    m_ovf = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1;

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) == 0),
          bit'($urandom_range(0, 40) == 0), $urandom, AWL'($urandom));
    end
    cyc(0, 0, 0, '0, '0);
    @(posedge CLK);
    #2;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
